// File: rtl/shift_seq8.sv
// shift_seq8: multi-cycle LSL/LSR/ASR sequencer, at most 3 bits per pass through one shifter.
// Optional rotate-right for op=11 when SHIFT_SEQ_ROR_EN is defined; otherwise op=11 flags err.
module shift_seq8 #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] d_in,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d_out,
    output logic             err
);
    localparam int REM_W = 4;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, dout_q, dout_d, sh;
    logic signed [WIDTH-1:0] asr;
    logic [REM_W-1:0] rem_q, rem_d, rem_nxt, rem_ld, amt_cap;
    logic [1:0] op_q, op_d, step;
    logic err_q, err_d, accept, last, unsup;
    assign accept  = start && state_q != SHIFT;
    assign step    = (rem_q > REM_W'(3)) ? 2'd3 : rem_q[1:0];
    assign rem_nxt = rem_q - REM_W'(step);
    assign last    = rem_nxt == '0;
    assign amt_cap = (int'(amt) > WIDTH) ? REM_W'(WIDTH) : REM_W'(amt);
    assign asr     = $signed(acc_q) >>> step;
`ifdef SHIFT_SEQ_ROR_EN
    logic [WIDTH-1:0] ror;
    assign ror    = (acc_q >> step) | (acc_q << (REM_W'(WIDTH) - REM_W'(step)));
    assign rem_ld = (op == 2'b11) ? REM_W'(amt[2:0]) : amt_cap;
    assign unsup  = 1'b0;
    assign sh     = op_q == 2'b00 ? acc_q << step : op_q == 2'b01 ? acc_q >> step :
                    op_q == 2'b10 ? asr : ror;
`else
    // op=11 is a single zero-step pass so the operand comes back unchanged with err
    assign rem_ld = (op == 2'b11) ? '0 : amt_cap;
    assign unsup  = op_q == 2'b11;
    assign sh     = op_q == 2'b00 ? acc_q << step : op_q == 2'b01 ? acc_q >> step :
                    op_q == 2'b10 ? asr : acc_q;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end
    always_comb state_d = state_q == SHIFT ? (last ? DONE : SHIFT) : (start ? SHIFT : IDLE);
    always_comb begin
        acc_d  = acc_q;
        rem_d  = rem_q;
        op_d   = op_q;
        err_d  = err_q;
        dout_d = dout_q;
        if (accept) begin
            acc_d = d_in;
            rem_d = rem_ld;
            op_d  = op;
            err_d = 1'b0;
        end else if (state_q == SHIFT) begin
            acc_d = sh;
            rem_d = rem_nxt;
            if (last) begin
                dout_d = sh;
                err_d  = unsup;
            end
        end
    end
    always_comb begin
        busy  = state_q == SHIFT;
        done  = state_q == DONE;
        d_out = dout_q;
        err   = err_q;
    end
endmodule

// File: tb/tb_shift_seq8.sv
// tb_shift_seq8: directed checks of shift_seq8 against a request-level model.
// Honours SHIFT_SEQ_ROR_EN the same way as the design.
module tb_shift_seq8;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [1:0] op = '0;
    logic [7:0] d_in = '0;
    logic [3:0] amt = '0;
    logic busy, done, err;
    logic [7:0] d_out;
    int n_cmp = 0, n_bad = 0;

    shift_seq8 dut (.clk(clk), .reset(reset), .start(start), .op(op), .d_in(d_in),
                    .amt(amt), .busy(busy), .done(done), .d_out(d_out), .err(err));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-request result from the shift rules, not from passes
    function automatic logic [8:0] model_res(input logic [1:0] o, input logic [7:0] d, input logic [3:0] a);
        int s = (a > 8) ? 8 : int'(a);
        logic signed [7:0] sr;
        logic [15:0] dd;
        sr = $signed(d) >>> s;
        dd = {d, d} >> (a % 8);
        case (o)
            2'd0: return {1'b0, 8'(d << s)};
            2'd1: return {1'b0, 8'(d >> s)};
            2'd2: return {1'b0, sr};
`ifdef SHIFT_SEQ_ROR_EN
            default: return {1'b0, dd[7:0]};
`else
            default: return {1'b1, d};
`endif
        endcase
    endfunction

    function automatic int model_passes(input logic [1:0] o, input logic [3:0] a);
        int r = (a > 8) ? 8 : int'(a);
`ifdef SHIFT_SEQ_ROR_EN
        if (o == 2'd3) r = a % 8;
`else
        if (o == 2'd3) r = 0;
`endif
        return (r == 0) ? 1 : (r + 2) / 3;
    endfunction

    int cnt = 0;
    logic m_done = 1'b0, m_err = 1'b0, p_err = 1'b0;
    logic [7:0] m_dout = '0, p_res = '0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 0;
            m_done <= 1'b0;
            m_dout <= '0;
            m_err <= 1'b0;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            m_done <= (cnt == 1);
            if (cnt == 1) begin
                m_dout <= p_res;
                m_err <= p_err;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                {p_err, p_res} <= model_res(op, d_in, amt);
                cnt <= model_passes(op, amt);
            end
        end
    end

    always @(negedge clk) begin
        check("busy", busy, cnt != 0);
        check("done", done, m_done);
        check("d_out", d_out, m_dout);
        if (m_done) check("err", err, m_err);
    end

    task automatic run(input logic [1:0] o, input logic [7:0] d, input logic [3:0] a,
                       input bit lit, input logic [7:0] ed, input bit ee, input int el);
        int lat = 1;
        bit got = 0;
        start = 1'b1; op = o; d_in = d; amt = a;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) got = 1;
        end
        if (!got) check("done_timeout", 0, 1);
        else if (lit) begin
            check("lat", lat, el);
            check("res", d_out, ed);
            check("res_err", err, ee);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout", d_out, 8'h00);
        check("rst_err", err, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        run(2'd0, 8'h81, 4'd1, 1, 8'h02, 0, 2);
        run(2'd2, 8'h80, 4'd7, 1, 8'hFF, 0, 4);
        run(2'd1, 8'hF0, 4'd12, 1, 8'h00, 0, 4);
        run(2'd2, 8'h80, 4'd15, 1, 8'hFF, 0, 4);
        run(2'd2, 8'h5A, 4'd0, 1, 8'h5A, 0, 2);
`ifdef SHIFT_SEQ_ROR_EN
        run(2'd3, 8'h81, 4'd9, 1, 8'hC0, 0, 2);
`else
        run(2'd3, 8'h81, 4'd9, 1, 8'h81, 1, 2);
`endif
        @(posedge clk); #1;
        // start while busy is dropped
        start = 1'b1; op = 2'd1; d_in = 8'hFF; amt = 4'd6;
        @(posedge clk); #1 op = 2'd0; d_in = 8'h01; amt = 4'd1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        check("ign_done", done, 1);
        check("ign_res", d_out, 8'h03);
        @(posedge clk); #1;
        check("ign_nodone", done, 0);
        check("ign_idle", busy, 0);
        // start held into DONE is taken back-to-back
        start = 1'b1; op = 2'd0; d_in = 8'h01; amt = 4'd3;
        @(posedge clk); #1 op = 2'd1; d_in = 8'h80; amt = 4'd2;
        @(posedge clk); #1;
        check("b2b_done1", done, 1);
        check("b2b_res1", d_out, 8'h08);
        @(posedge clk); #1 start = 1'b0;
        check("b2b_busy", busy, 1);
        @(posedge clk); #1;
        check("b2b_done2", done, 1);
        check("b2b_res2", d_out, 8'h20);
        // reset in SHIFT aborts with no result
        start = 1'b1; op = 2'd0; d_in = 8'hFF; amt = 4'd8;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        #2;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dout", d_out, 8'h00);
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check("abort_nodone", done, 0);
        end
        foreach (amt_list[k]) for (int o = 0; o < 4; o++)
            run(2'(o), 8'hB5, amt_list[k], 0, 8'h00, 0, 0);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    logic [3:0] amt_list [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd15};
endmodule
